// File: rtl/fp_acc_seq.sv
// Sequencer for the floating-point accumulator: streams len terms into the
// accumulator, waits out its latency, then captures the sum and flags.
module fp_acc_seq #(
  parameter int ACC_LATENCY = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [31:0]      acc_x,
  output logic             acc_n,
  output logic             acc_en,
  input  logic [31:0]      acc_r,
  input  logic             acc_xo,
  input  logic             acc_xu,
  input  logic             acc_ao,
  output logic [31:0]      result,
  output logic             xo,
  output logic             xu,
  output logic             ao,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int DW = $clog2(ACC_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] remaining;
  logic [DW-1:0]    drain_cnt;
  logic             first;
  logic             accept;

  // Handshake: a term transfers on an edge where in_valid & in_ready & clk_en;
  // in_ready is only raised in RUN and is forced low while clk_en is low.
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        in_ready = clk_en;
        accept   = in_valid & clk_en;
        if (in_valid && remaining == CNT_W'(1)) state_n = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == '0) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else if (clk_en) state <= state_n;
  end

  // Every enabled cycle feeds the accumulator; idle cycles feed +0.0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_x     <= 32'h0;
      acc_n     <= 1'b0;
      result    <= 32'h0;
      xo        <= 1'b0;
      xu        <= 1'b0;
      ao        <= 1'b0;
      remaining <= '0;
      drain_cnt <= '0;
      first     <= 1'b0;
    end else if (clk_en) begin
      acc_x <= accept ? in_data : 32'h0;
      acc_n <= accept & first;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= len;
            first     <= 1'b1;
            xo        <= 1'b0;
            xu        <= 1'b0;
            ao        <= 1'b0;
            if (len == '0) result <= 32'h0;
          end
        end
        RUN: begin
          if (accept) begin
            remaining <= remaining - CNT_W'(1);
            first     <= 1'b0;
            if (remaining == CNT_W'(1)) drain_cnt <= DW'(ACC_LATENCY);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            result <= acc_r;
            xo     <= acc_xo;
            xu     <= acc_xu;
            ao     <= acc_ao;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign acc_en    = clk_en;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_fp_acc_seq.sv
// Directed bench for fp_acc_seq with a behavioural single-precision
// accumulator model standing in for the accumulator core.
module tb_fp_acc_seq;
  localparam int L = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, acc_n, acc_en, xo, xu, ao, busy, done;
  logic [31:0] acc_x, acc_r, result;
  logic        acc_xo, acc_xu, acc_ao;
  logic [1:0]  state_dbg;

  fp_acc_seq #(.ACC_LATENCY(L), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .clk_en(clk_en), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .acc_x(acc_x), .acc_n(acc_n), .acc_en(acc_en), .acc_r(acc_r),
    .acc_xo(acc_xo), .acc_xu(acc_xu), .acc_ao(acc_ao),
    .result(result), .xo(xo), .xu(xu), .ao(ao),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] terms[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(int'(b[22:0])) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real         a;
    int          e;
    logic [31:0] m;
    logic        s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = 32'(longint'((a - 1.0) * 8388608.0));
    return {s, 8'(e + 127), m[22:0]};
  endfunction

  // behavioural accumulator: L enabled cycles from acc_x to acc_r
  real         m_sum;
  logic        m_ovf;
  logic [31:0] m_r[L];
  logic        m_xo[L];
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_sum = 0.0;
      m_ovf = 1'b0;
      for (int i = 0; i < L; i++) begin m_r[i] <= 32'h0; m_xo[i] <= 1'b0; end
    end else if (acc_en) begin
      m_sum = acc_n ? f2r(acc_x) : m_sum + f2r(acc_x);
      m_ovf = acc_n ? 1'b0 : m_ovf;
      if (m_sum > f2r(32'h7F7FFFFF)) m_ovf = 1'b1;
      m_r[0]  <= m_ovf ? 32'h7F800000 : r2f(m_sum);
      m_xo[0] <= m_ovf;
      for (int i = 1; i < L; i++) begin m_r[i] <= m_r[i-1]; m_xo[i] <= m_xo[i-1]; end
    end
  end
  assign acc_r  = m_r[L-1];
  assign acc_xo = m_xo[L-1];
  assign acc_xu = 1'b0;
  assign acc_ao = 1'b0;

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_cmd(input int n, input int gap, input int frz_run, input bit frz_drain,
                         input bit poke_start, input logic [31:0] exp_r, input logic exp_xo);
    int cyc;
    exp_q.push_back(exp_r);
    start = 1'b1; len = 16'(n); in_valid = 1'b1; in_data = terms[0];
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_no_accept", acc_x, 32'h0);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = terms[i];
      step();
      in_valid = 1'b0;
      check("term_x", acc_x, terms[i]);
      check("term_n", acc_n, (i == 0));
      if (i == frz_run) begin
        clk_en = 1'b0; in_valid = 1'b1;
        repeat (5) begin
          step();
          check("frz_ready", in_ready, 0);
          check("frz_x", acc_x, terms[i]);
        end
        clk_en = 1'b1; in_valid = 1'b0;
      end
      if (i < n - 1) repeat (gap) begin
        step();
        check("bubble_x", acc_x, 32'h0);
        check("bubble_n", acc_n, 0);
      end
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      start = poke_start && (cyc == 1); len = 16'd1;
      if (frz_drain && cyc == 1) clk_en = 1'b0;
      if (frz_drain && cyc == 6) clk_en = 1'b1;
      step();
      cyc++;
      start = 1'b0;
      if (done !== 1'b1) check("drain_x", acc_x, 32'h0);
    end
    check("done_delay", cyc, frz_drain ? L + 6 : L + 1);
    check("result", result, exp_q.pop_front());
    check("xo", xo, exp_xo);
    check("xu", xu, 0);
    check("ao", ao, 0);
    check("done_busy", busy, 1);
    step();
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int saw_done;
    #1;
    check("rst_result", result, 32'h0);
    check("rst_x", acc_x, 32'h0);
    check("rst_n", acc_n, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flags", {xo, xu, ao}, 0);
    step();
    reset = 1'b0;
    step();

    terms[0] = 32'h3F800000; terms[1] = 32'h40000000;
    terms[2] = 32'h40400000; terms[3] = 32'h40800000;
    run_cmd(4, 0, -1, 1'b0, 1'b0, 32'h41200000, 1'b0);
    run_cmd(4, 2, -1, 1'b0, 1'b1, 32'h41200000, 1'b0);
    run_cmd(4, 0, 1, 1'b1, 1'b0, 32'h41200000, 1'b0);

    terms[0] = 32'h7F7FFFFF; terms[1] = 32'h7F7FFFFF;
    run_cmd(2, 0, -1, 1'b0, 1'b0, 32'h7F800000, 1'b1);

    // zero-length command after an overflowed sum
    start = 1'b1; len = 16'd0;
    step();
    start = 1'b0;
    check("len0_done", done, 1);
    check("len0_busy", busy, 1);
    check("len0_result", result, 32'h0);
    check("len0_xo", xo, 0);
    check("len0_n", acc_n, 0);
    step();
    check("len0_pulse", done, 0);
    check("len0_n2", acc_n, 0);

    terms[0] = 32'h3F800000;
    run_cmd(1, 0, -1, 1'b0, 1'b0, 32'h3F800000, 1'b0);

    // reset in the middle of DRAIN
    terms[0] = 32'h3F800000; terms[1] = 32'h40000000;
    terms[2] = 32'h40400000; terms[3] = 32'h40800000;
    start = 1'b1; len = 16'd4; in_valid = 1'b1; in_data = terms[0];
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin in_data = terms[i]; step(); end
    in_valid = 1'b0;
    step();
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result", result, 32'h0);
    check("mid_rst_x", acc_x, 32'h0);
    check("mid_rst_done", done, 0);
    step();
    reset = 1'b0;
    saw_done = 0;
    repeat (8) begin step(); if (done === 1'b1) saw_done++; end
    check("no_done_after_rst", saw_done, 0);
    terms[0] = 32'h40000000;
    run_cmd(1, 0, -1, 1'b0, 1'b0, 32'h40000000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end
endmodule

// File: doc/fp_acc_seq.md
Name: fp_acc_seq

Overview:
- Sequencer that owns the floating-point accumulator (fp_acc_target) in the cosine CORDIC accelerator.
- Accepts a start command with a term count, streams that many IEEE-754 single-precision terms into the accumulator, then waits out its pipeline latency.
- Captures the sum and the xo/xu/ao flags, and pulses done.
- Sits between the Nios custom-instruction front end / CORDIC term producer and the accumulator core.

Parameters:
- ACC_LATENCY, 3: enabled cycles from a term on acc_x to its effect on acc_r; must be >= 1.
- CNT_W, 16: width of the term count.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  global enable; low freezes the whole block
- start  in  1  command strobe, sampled only in IDLE
- len  in  CNT_W  number of terms, latched on accepted start
- in_valid  in  1  term valid
- in_data  in  32  term, IEEE-754 single
- in_ready  out  1  term accepted when in_valid & in_ready & clk_en
- acc_x  out  32  accumulator x input (registered)
- acc_n  out  1  accumulator n (new-sum) input (registered)
- acc_en  out  1  accumulator en
- acc_r  in  32  accumulator sum
- acc_xo, acc_xu, acc_ao  in  1 each  accumulator overflow, underflow and accumulator-overflow flags
- result  out  32  captured sum, held until the next accepted start
- xo, xu, ao  out  1 each  captured flags
- busy  out  1  high outside IDLE
- done  out  1  single-cycle completion pulse (one enabled cycle)

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - result, acc_x = 32'h0.
  - acc_n, in_ready, busy, done, xo, xu, ao = 0.
  - Counters = 0.
- acc_en = clk_en, combinational. The accumulator sums every enabled cycle, so every enabled cycle presents a defined acc_x.
- Bubble rule: any enabled cycle with no accepted term drives acc_x=32'h0 (+0.0) and acc_n=0.
- clk_en low: every register holds, including state, counters, acc_x, acc_n, result and done. in_ready is forced 0.
- All transitions below occur only on clock edges with clk_en=1.
- IDLE:
  - in_ready=0.
  - start=1 latches len into remaining and clears xo/xu/ao.
  - len=0 -> DONE: result=32'h0, flags=0.
  - len!=0 -> RUN.
- RUN:
  - in_ready=1.
  - Each accepted term: acc_x<=in_data; acc_n<=1 for the first term of the command, else 0; remaining-=1.
  - The term that makes remaining 0 moves to DRAIN, with drain counter = ACC_LATENCY.
- DRAIN:
  - in_ready=0; acc_x=0; acc_n=0.
  - Drain counter decrements each enabled cycle.
  - When it reaches 0: result<=acc_r; xo/xu/ao<=acc_xo/acc_xu/acc_ao; go to DONE.
- DONE:
  - done=1 for exactly one enabled cycle, then IDLE.
  - result and flags stay stable from DONE until the next accepted start.
- Latency:
  - Last term accepted at enabled edge E.
  - result and flags are loaded at enabled edge E+ACC_LATENCY+1.
  - done is high during the following enabled cycle.
  - The count is exclusive of clk_en-low cycles.
- Busy: busy=1 in RUN, DRAIN and DONE. start during busy is ignored and not queued.
- Start: start and in_valid may be high in the same cycle. The term is not accepted until RUN (in_ready=0 in IDLE).
- Back-to-back: start may be accepted in the cycle after DONE. acc_n=1 on the first term guarantees the prior sum is discarded.
- Reset mid-operation: immediate return to reset values. No done is issued for the aborted command. The accumulator shares the same reset.
- Arithmetic: no float arithmetic in this block. Counters wrap never; len <= 2^CNT_W-1.

Test Plan:
- len=4, terms 3F800000, 40000000, 40400000, 40800000 on consecutive cycles, ACC_LATENCY=3 -> acc_n high only with the first term; done exactly 4 enabled edges after the last accept; result=41200000 (10.0); xo=xu=ao=0.
- Same four terms with in_valid low for 2 cycles between each term -> acc_x=0 on every bubble cycle; result=41200000; done timed from the last accept.
- len=0 start -> busy high; done on the next enabled cycle; result=00000000; no acc_n pulse.
- len=2, terms 7F7FFFFF, 7F7FFFFF (behavioural accumulator model raising xo) -> xo=1 captured with result. Then start len=1, term 3F800000 -> result=3F800000, xo=0.
- clk_en held low 5 cycles mid-RUN and mid-DRAIN -> in_ready=0; all outputs frozen; done delay extended by exactly 5; result=41200000 for the 10.0 sequence.
- reset asserted during DRAIN -> all outputs 0 immediately; no done. A following len=1 term 40000000 -> result=40000000.
